instr_fetch_unit: RTL and testbench

- Initiator side of the 8-bit instruction/data memory interface (13-bit byte address, mem_read/command).
- Holds the program counter and issues byte reads.
- Assembles 1-byte and 2-byte instructions and hands each completed instruction to the controller/execute stage through a valid/ready handshake.
- Supports jump redirection and yields the shared memory bus when bus_grant is low.

---
 rtl/instr_fetch_unit.sv | 92 +++++++++
 tb/tb_instr_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: byte-wide memory initiator that assembles
// 1- and 2-byte instructions and hands them off via valid/ready.
module instr_fetch_unit #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] address,
    output logic              mem_read,
    input  logic [DATA_W-1:0] command,
    input  logic              bus_grant,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr,
    output logic              instr_two_byte,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr
);

    typedef enum logic [1:0] {FETCH1, FETCH2, HOLD} state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] pc;
    logic              is_two;
    logic              fetching;

    // Memory-reference ops (0xx) and JMP (110) carry a second address byte
    assign is_two = ~command[7] | (command[7:5] == 3'b110);

    assign fetching    = (state == FETCH1) || (state == FETCH2);
    assign mem_read    = ~rst & bus_grant & fetching;
    assign address     = pc;
    assign instr_valid = (state == HOLD);
    assign mem_addr    = instr[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH1;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (jump_en) begin
            state_n = FETCH1;
        end else begin
            case (state)
                FETCH1: if (bus_grant) state_n = is_two ? FETCH2 : HOLD;
                FETCH2: if (bus_grant) state_n = HOLD;
                HOLD:   if (instr_ready) state_n = FETCH1;
                default: state_n = FETCH1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            instr          <= '0;
            instr_two_byte <= 1'b0;
            instr_pc       <= '0;
        end else if (jump_en) begin
            pc <= jump_addr;
        end else begin
            case (state)
                FETCH1: begin
                    if (bus_grant) begin
                        instr          <= {command[7:0], 8'h00};
                        instr_two_byte <= is_two;
                        instr_pc       <= pc;
                        pc             <= pc + ADDR_W'(1);
                    end
                end
                FETCH2: begin
                    if (bus_grant) begin
                        instr[7:0] <= command[7:0];
                        pc         <= pc + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational byte memory
// model; expected values are hand-derived from the instruction stream.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] address;
    logic              mem_read;
    logic [7:0]        command;
    logic              bus_grant;
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic              instr_two_byte;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] mem_addr;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;

    logic [7:0] mem [0:8191];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign command = mem[address];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .mem_read       (mem_read),
        .command        (command),
        .bus_grant      (bus_grant),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_two_byte (instr_two_byte),
        .instr_pc       (instr_pc),
        .mem_addr       (mem_addr),
        .jump_en        (jump_en),
        .jump_addr      (jump_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[0]  = 8'hE9;
        mem[1]  = 8'h03;
        mem[2]  = 8'hE8;
        mem[3]  = 8'h20;
        mem[4]  = 8'h55;
        mem[10] = 8'h41;
        mem[11] = 8'h77;

        rst = 1'b1; bus_grant = 1'b1; instr_ready = 1'b1;
        jump_en = 1'b0; jump_addr = '0;
        #1;
        chk("rd_in_rst", 32'(mem_read), 32'd0);
        step();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_two", 32'(instr_two_byte), 32'd0);
        chk("rst_ipc", 32'(instr_pc), 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        rst = 1'b0;
        #1;
        chk("f1_rd", 32'(mem_read), 32'd1);

        // 1-byte LDI at 0
        step();
        chk("ldi_valid", 32'(instr_valid), 32'd1);
        chk("ldi_instr", 32'(instr), 32'hE900);
        chk("ldi_two", 32'(instr_two_byte), 32'd0);
        chk("ldi_ipc", 32'(instr_pc), 32'd0);
        chk("hold_rd", 32'(mem_read), 32'd0);
        chk("ldi_pc", 32'(address), 32'd1);
        step();
        chk("acc_valid", 32'(instr_valid), 32'd0);
        chk("nxt_addr", 32'(address), 32'd1);
        chk("nxt_rd", 32'(mem_read), 32'd1);

        // 2-byte LDA 1000 at 1
        step();
        chk("f2_valid", 32'(instr_valid), 32'd0);
        chk("f2_addr", 32'(address), 32'd2);
        step();
        chk("lda_instr", 32'(instr), 32'h03E8);
        chk("lda_two", 32'(instr_two_byte), 32'd1);
        chk("lda_maddr", 32'(mem_addr), 32'd1000);
        chk("lda_ipc", 32'(instr_pc), 32'd1);
        chk("lda_pc", 32'(address), 32'd3);

        // consumer stall for 5 cycles
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", 32'(instr), 32'h03E8);
            chk("stall_ipc", 32'(instr_pc), 32'd1);
            chk("stall_rd", 32'(mem_read), 32'd0);
        end
        instr_ready = 1'b1;
        step();
        chk("stall_acc", 32'(instr_valid), 32'd0);
        chk("stall_addr", 32'(address), 32'd3);

        // STA at 3 with bus_grant withheld in FETCH2
        step();
        chk("sta_f2", 32'(address), 32'd4);
        bus_grant = 1'b0;
        #1;
        chk("ng_rd0", 32'(mem_read), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ng_rd", 32'(mem_read), 32'd0);
            chk("ng_addr", 32'(address), 32'd4);
            chk("ng_valid", 32'(instr_valid), 32'd0);
        end
        bus_grant = 1'b1;
        step();
        chk("sta_valid", 32'(instr_valid), 32'd1);
        chk("sta_instr", 32'(instr), 32'h2055);
        chk("sta_ipc", 32'(instr_pc), 32'd3);
        chk("sta_maddr", 32'(mem_addr), 32'h055);
        chk("sta_pc", 32'(address), 32'd5);

        // jump while holding, with instr_ready=1
        jump_en = 1'b1; jump_addr = 13'd10;
        step();
        jump_en = 1'b0;
        chk("jh_valid", 32'(instr_valid), 32'd0);
        chk("jh_addr", 32'(address), 32'd10);
        step();
        chk("ada_f2", 32'(address), 32'd11);
        // jump during FETCH2 drops the partial instruction
        jump_en = 1'b1;
        step();
        jump_en = 1'b0;
        chk("jf_valid", 32'(instr_valid), 32'd0);
        chk("jf_addr", 32'(address), 32'd10);
        step();
        step();
        chk("ada_valid", 32'(instr_valid), 32'd1);
        chk("ada_instr", 32'(instr), 32'h4177);
        chk("ada_ipc", 32'(instr_pc), 32'd10);
        chk("ada_two", 32'(instr_two_byte), 32'd1);

        // JMP straddling the top of memory
        mem[8191] = 8'hC0;
        mem[0]    = 8'h0A;
        jump_en = 1'b1; jump_addr = 13'd8191;
        step();
        jump_en = 1'b0;
        chk("wr_addr", 32'(address), 32'd8191);
        step();
        chk("wr_f2", 32'(address), 32'd0);
        step();
        chk("jmp_instr", 32'(instr), 32'hC00A);
        chk("jmp_maddr", 32'(mem_addr), 32'd10);
        chk("jmp_ipc", 32'(instr_pc), 32'd8191);
        chk("jmp_pc", 32'(address), 32'd1);

        // reset in FETCH2, with a competing jump
        step();
        step();
        chk("pre_rst", 32'(address), 32'd2);
        rst = 1'b1; jump_en = 1'b1; jump_addr = 13'd10;
        #1;
        chk("rst_rd", 32'(mem_read), 32'd0);
        step();
        rst = 1'b0; jump_en = 1'b0;
        chk("r2_addr", 32'(address), 32'd0);
        chk("r2_valid", 32'(instr_valid), 32'd0);
        chk("r2_instr", 32'(instr), 32'd0);
        step();
        step();
        chk("r2_valid2", 32'(instr_valid), 32'd1);
        chk("r2_instr2", 32'(instr), 32'h0A03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
